// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: owns paddle, ball, score and phase state and advances it once per frame tick.
// Serve / play / point / game-over flow with start-switch abort and pause freeze.
module pong_game_ctrl #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 80,
    parameter int PADDLE_X1    = 20,
    parameter int PADDLE_X2    = 610,
    parameter int BALL_SIZE    = 10,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_STEP  = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       frame_tick,
    input  logic [7:0] key1_code,
    input  logic [7:0] key2_code,
    input  logic       start,
    input  logic       pause,
    output logic [9:0] paddle1_y,
    output logic [9:0] paddle2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [2:0] game_state,
    output logic [1:0] winner,
    output logic       hit_pulse
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [7:0] KEY1_UP = 8'h1D;
    localparam logic [7:0] KEY1_DN = 8'h1B;
    localparam logic [7:0] KEY2_UP = 8'h75;
    localparam logic [7:0] KEY2_DN = 8'h72;

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [10:0] HRES_W  = 11'(H_RES);
    localparam logic [10:0] VRES_W  = 11'(V_RES);
    localparam logic [10:0] PW_W    = 11'(PADDLE_W);
    localparam logic [10:0] PH_W    = 11'(PADDLE_H);
    localparam logic [10:0] PX1_W   = 11'(PADDLE_X1);
    localparam logic [10:0] PX2_W   = 11'(PADDLE_X2);
    localparam logic [10:0] SIZE_W  = 11'(BALL_SIZE);
    localparam logic [10:0] SPEED_W = 11'(BALL_SPEED);
    localparam logic [10:0] STEP_W  = 11'(PADDLE_STEP);
    localparam logic [10:0] PMAX_W  = 11'(V_RES - PADDLE_H);

    localparam logic [9:0] PADDLE_Y0 = 10'((V_RES - PADDLE_H) / 2);
    localparam logic [9:0] BALL_X0   = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y0   = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [3:0] WIN_W     = 4'(WIN_SCORE);

    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    state_t           state, state_nxt;
    logic [9:0]       p1_nxt, p2_nxt, bx_nxt, by_nxt;
    logic [3:0]       s1_nxt, s2_nxt;
    logic [1:0]       win_nxt;
    logic             hit_nxt;
    logic             dir_x, dir_x_nxt;     // 1 = moving right
    logic             dir_y, dir_y_nxt;     // 1 = moving down
    logic [CNT_W-1:0] serve_cnt, cnt_nxt;
    logic             point_p2, point_p2_nxt;

    logic [10:0] bx_ext, by_ext, p1_ext, p2_ext;
    logic [9:0]  p1_step, p2_step, bx_step, by_step;
    logic        dir_x_step, dir_y_step;
    logic        wall_hit, pad_hit, miss;
    logic        overlap1, overlap2;

    function automatic logic [9:0] paddle_move(input logic [9:0] pos, input logic [7:0] code,
                                               input logic [7:0] up_code, input logic [7:0] dn_code);
        logic [10:0] p;
        p = {1'b0, pos};
        if (code == up_code)
            p = (p < STEP_W) ? '0 : p - STEP_W;
        else if (code == dn_code)
            p = (p + STEP_W > PMAX_W) ? PMAX_W : p + STEP_W;
        return 10'(p);
    endfunction

    assign bx_ext = {1'b0, ball_x};
    assign by_ext = {1'b0, ball_y};
    assign p1_ext = {1'b0, paddle1_y};
    assign p2_ext = {1'b0, paddle2_y};

    assign p1_step = paddle_move(paddle1_y, key1_code, KEY1_UP, KEY1_DN);
    assign p2_step = paddle_move(paddle2_y, key2_code, KEY2_UP, KEY2_DN);

    // Overlap is judged on the positions before this frame's update.
    assign overlap1 = (by_ext + SIZE_W > p1_ext) && (by_ext < p1_ext + PH_W);
    assign overlap2 = (by_ext + SIZE_W > p2_ext) && (by_ext < p2_ext + PH_W);

    always_comb begin
        by_step    = ball_y;
        dir_y_step = dir_y;
        wall_hit   = 1'b0;
        if (!dir_y && by_ext <= SPEED_W) begin
            by_step    = '0;
            dir_y_step = 1'b1;
            wall_hit   = 1'b1;
        end else if (dir_y && by_ext + SIZE_W + SPEED_W >= VRES_W) begin
            by_step    = 10'(VRES_W - SIZE_W);
            dir_y_step = 1'b0;
            wall_hit   = 1'b1;
        end else if (dir_y) begin
            by_step = 10'(by_ext + SPEED_W);
        end else begin
            by_step = 10'(by_ext - SPEED_W);
        end
    end

    always_comb begin
        bx_step    = ball_x;
        dir_x_step = dir_x;
        pad_hit    = 1'b0;
        miss       = 1'b0;
        if (!dir_x) begin
            if (bx_ext <= PX1_W + PW_W && bx_ext >= PX1_W && overlap1) begin
                bx_step    = 10'(PX1_W + PW_W);
                dir_x_step = 1'b1;
                pad_hit    = 1'b1;
            end else if (bx_ext <= SPEED_W) begin
                bx_step = '0;
                miss    = 1'b1;
            end else begin
                bx_step = 10'(bx_ext - SPEED_W);
            end
        end else begin
            if (bx_ext + SIZE_W >= PX2_W && bx_ext + SIZE_W <= PX2_W + PW_W && overlap2) begin
                bx_step    = 10'(PX2_W - SIZE_W);
                dir_x_step = 1'b0;
                pad_hit    = 1'b1;
            end else if (bx_ext + SIZE_W + SPEED_W >= HRES_W) begin
                bx_step = 10'(HRES_W - SIZE_W);
                miss    = 1'b1;
            end else begin
                bx_step = 10'(bx_ext + SPEED_W);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        p1_nxt       = paddle1_y;
        p2_nxt       = paddle2_y;
        bx_nxt       = ball_x;
        by_nxt       = ball_y;
        s1_nxt       = score1;
        s2_nxt       = score2;
        win_nxt      = winner;
        hit_nxt      = 1'b0;
        dir_x_nxt    = dir_x;
        dir_y_nxt    = dir_y;
        cnt_nxt      = serve_cnt;
        point_p2_nxt = point_p2;

        // Dropping the start switch aborts from any phase, even while paused.
        if (state != IDLE && !start) begin
            state_nxt    = IDLE;
            p1_nxt       = PADDLE_Y0;
            p2_nxt       = PADDLE_Y0;
            bx_nxt       = BALL_X0;
            by_nxt       = BALL_Y0;
            s1_nxt       = '0;
            s2_nxt       = '0;
            win_nxt      = '0;
            dir_x_nxt    = 1'b1;
            dir_y_nxt    = 1'b1;
            cnt_nxt      = '0;
            point_p2_nxt = 1'b0;
        end else if (!pause) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = SERVE;
                        s1_nxt    = '0;
                        s2_nxt    = '0;
                        win_nxt   = '0;
                    end
                end
                SERVE: begin
                    if (frame_tick) begin
                        p1_nxt = p1_step;
                        p2_nxt = p2_step;
                        if (serve_cnt == SERVE_LAST) begin
                            cnt_nxt   = '0;
                            state_nxt = PLAY;
                        end else begin
                            cnt_nxt = serve_cnt + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (frame_tick) begin
                        p1_nxt    = p1_step;
                        p2_nxt    = p2_step;
                        bx_nxt    = bx_step;
                        by_nxt    = by_step;
                        dir_x_nxt = dir_x_step;
                        dir_y_nxt = dir_y_step;
                        hit_nxt   = wall_hit | pad_hit;
                        if (miss) begin
                            state_nxt    = POINT;
                            point_p2_nxt = !dir_x;
                        end
                    end
                end
                POINT: begin
                    state_nxt = SERVE;
                    bx_nxt    = BALL_X0;
                    by_nxt    = BALL_Y0;
                    if (point_p2) begin
                        s2_nxt    = (score2 >= WIN_W) ? WIN_W : score2 + 1'b1;
                        dir_x_nxt = 1'b0;
                        if (s2_nxt == WIN_W) begin
                            state_nxt = OVER;
                            win_nxt   = 2'd2;
                            bx_nxt    = ball_x;
                            by_nxt    = ball_y;
                            dir_x_nxt = dir_x;
                        end
                    end else begin
                        s1_nxt    = (score1 >= WIN_W) ? WIN_W : score1 + 1'b1;
                        dir_x_nxt = 1'b1;
                        if (s1_nxt == WIN_W) begin
                            state_nxt = OVER;
                            win_nxt   = 2'd1;
                            bx_nxt    = ball_x;
                            by_nxt    = ball_y;
                            dir_x_nxt = dir_x;
                        end
                    end
                end
                OVER: begin
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            paddle1_y <= PADDLE_Y0;
            paddle2_y <= PADDLE_Y0;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            score1    <= '0;
            score2    <= '0;
            winner    <= '0;
            hit_pulse <= 1'b0;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            serve_cnt <= '0;
            point_p2  <= 1'b0;
        end else begin
            state     <= state_nxt;
            paddle1_y <= p1_nxt;
            paddle2_y <= p2_nxt;
            ball_x    <= bx_nxt;
            ball_y    <= by_nxt;
            score1    <= s1_nxt;
            score2    <= s2_nxt;
            winner    <= win_nxt;
            hit_pulse <= hit_nxt;
            dir_x     <= dir_x_nxt;
            dir_y     <= dir_y_nxt;
            serve_cnt <= cnt_nxt;
            point_p2  <= point_p2_nxt;
        end
    end

    assign game_state = state;

endmodule
